// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer
//   Digit stack for the seven-segment front end. Debounced one-cycle strobes
//   push, backspace (pop), clear and commit a DIGITS-deep stack of DIGIT_W-bit
//   digits. The newest digit sits in number[DIGIT_W-1:0].
//
//   Ports:
//     clk          system clock, rising edge
//     RESET        synchronous active-high reset, overrides every strobe
//     push/pop     append din / remove newest digit; both together edits in place
//     clear        empty the buffer (wins over push/pop)
//     commit       latch the pre-edge number into value
//     din          digit to append
//     number       live buffer (registered)
//     an_mask      active-low occupancy mask, bit i = 0 iff slot i occupied
//     count        occupied slots 0..DIGITS
//     full/empty   combinational decode of count
//     value        last committed number
//     value_valid  one-cycle pulse the cycle after commit
//     overflow     one-cycle pulse: push while full
//     underflow    one-cycle pulse: pop while empty
//
//   Optional build macro DIGIT_ENTRY_BCD_CHECK_EN: pushes (and edits) with
//   din > 9 are rejected and pulse the extra output bad_digit.
//
//   FULL_MODE: 0 = push while full drops the oldest digit, 1 = push rejected.

module digit_entry_buffer #(
  parameter int DIGIT_W   = 4,
  parameter int DIGITS    = 8,
  parameter int FULL_MODE = 0
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        clear,
  input  logic                        commit,
  input  logic [DIGIT_W-1:0]          din,
  output logic [DIGIT_W*DIGITS-1:0]   number,
  output logic [DIGITS-1:0]           an_mask,
  output logic [$clog2(DIGITS+1)-1:0] count,
  output logic                        full,
  output logic                        empty,
  output logic [DIGIT_W*DIGITS-1:0]   value,
  output logic                        value_valid,
  output logic                        overflow,
  output logic                        underflow
`ifdef DIGIT_ENTRY_BCD_CHECK_EN
  ,
  output logic                        bad_digit
`endif
);

  localparam int NW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  logic [NW-1:0]     number_q, number_d;
  logic [NW-1:0]     value_q, value_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic              vv_q, vv_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              bad_q, bad_d;
  logic              full_c, empty_c;
  logic              digit_ok;

  assign full_c  = (count_q == CW'(DIGITS));
  assign empty_c = (count_q == '0);

`ifdef DIGIT_ENTRY_BCD_CHECK_EN
  // Narrow digits cannot encode a non-BCD value, so the check is moot there.
  assign digit_ok = (DIGIT_W < 4) || (din <= DIGIT_W'(9));
`else
  assign digit_ok = 1'b1;
`endif

  always_comb begin
    number_d = number_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    bad_d    = 1'b0;

    if (clear) begin
      number_d = '0;
      count_d  = '0;
    end else if (push && pop && !empty_c) begin
      // Edit in place: replace the newest digit, occupancy unchanged.
      if (digit_ok) number_d[DIGIT_W-1:0] = din;
      else          bad_d = 1'b1;
    end else if (push) begin
      // Also covers push+pop on an empty buffer.
      if (!digit_ok) begin
        bad_d = 1'b1;
      end else if (!full_c) begin
        number_d = (number_q << DIGIT_W) | NW'(din);
        count_d  = count_q + CW'(1);
      end else begin
        ovf_d = 1'b1;
        if (FULL_MODE == 0) number_d = (number_q << DIGIT_W) | NW'(din);
      end
    end else if (pop) begin
      if (!empty_c) begin
        number_d = number_q >> DIGIT_W;
        count_d  = count_q - CW'(1);
      end else begin
        unf_d = 1'b1;
      end
    end

    // Commit sees the pre-edge buffer, independent of this cycle's edit.
    value_d = commit ? number_q : value_q;
    vv_d    = commit;

    mask_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      mask_d[i] = (CW'(i) >= count_d);
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      number_q <= '0;
      value_q  <= '0;
      count_q  <= '0;
      mask_q   <= '1;
      vv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      number_q <= number_d;
      value_q  <= value_d;
      count_q  <= count_d;
      mask_q   <= mask_d;
      vv_q     <= vv_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      bad_q    <= bad_d;
    end
  end

  assign number      = number_q;
  assign value       = value_q;
  assign count       = count_q;
  assign an_mask     = mask_q;
  assign full        = full_c;
  assign empty       = empty_c;
  assign value_valid = vv_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

`ifdef DIGIT_ENTRY_BCD_CHECK_EN
  assign bad_digit = bad_q;
`else
  logic unused_bad;
  assign unused_bad = bad_q ^ bad_d;
`endif

endmodule

// File: tb/tb_digit_entry_buffer.sv
module tb_digit_entry_buffer;

  logic       clk = 1'b0;
  logic       RESET, push, pop, clear, commit;
  logic [3:0] din;

  logic [31:0] number0, number1, value0, value1;
  logic [7:0]  mask0, mask1;
  logic [3:0]  count0, count1;
  logic        full0, full1, empty0, empty1;
  logic        vv0, vv1, ovf0, ovf1, unf0, unf1;
`ifdef DIGIT_ENTRY_BCD_CHECK_EN
  logic        bad0, bad1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_entry_buffer #(.DIGIT_W(4), .DIGITS(8), .FULL_MODE(0)) u_drop (
    .clk(clk), .RESET(RESET), .push(push), .pop(pop), .clear(clear),
    .commit(commit), .din(din), .number(number0), .an_mask(mask0),
    .count(count0), .full(full0), .empty(empty0), .value(value0),
    .value_valid(vv0), .overflow(ovf0), .underflow(unf0)
`ifdef DIGIT_ENTRY_BCD_CHECK_EN
    , .bad_digit(bad0)
`endif
  );

  digit_entry_buffer #(.DIGIT_W(4), .DIGITS(8), .FULL_MODE(1)) u_rej (
    .clk(clk), .RESET(RESET), .push(push), .pop(pop), .clear(clear),
    .commit(commit), .din(din), .number(number1), .an_mask(mask1),
    .count(count1), .full(full1), .empty(empty1), .value(value1),
    .value_valid(vv1), .overflow(ovf1), .underflow(unf1)
`ifdef DIGIT_ENTRY_BCD_CHECK_EN
    , .bad_digit(bad1)
`endif
  );

  typedef struct {
    logic        pu, po, cl, cm;
    logic [3:0]  d;
    logic [31:0] n0, n1;
    int          c;
    logic [31:0] v0, v1;
    logic        vv, ov, un;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic pu, po, cl, cm, input logic [3:0] d,
                     input logic [31:0] n0, n1, input int c,
                     input logic [31:0] v0, v1, input logic vv, ov, un);
    vec_t t;
    t.pu = pu; t.po = po; t.cl = cl; t.cm = cm; t.d = d;
    t.n0 = n0; t.n1 = n1; t.c = c; t.v0 = v0; t.v1 = v1;
    t.vv = vv; t.ov = ov; t.un = un;
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] n0, n1, input int c,
                           input logic [31:0] v0, v1, input logic vv, ov, un);
    logic [15:0] m;
    m = 16'h00FF << c;
    chk({tag, " number0"}, number0, n0);
    chk({tag, " number1"}, number1, n1);
    chk({tag, " count0"},  32'(count0), 32'(c));
    chk({tag, " count1"},  32'(count1), 32'(c));
    chk({tag, " mask0"},   32'(mask0), 32'(m[7:0]));
    chk({tag, " mask1"},   32'(mask1), 32'(m[7:0]));
    chk({tag, " full"},    {30'd0, full0, full1},  {30'd0, c == 8, c == 8});
    chk({tag, " empty"},   {30'd0, empty0, empty1}, {30'd0, c == 0, c == 0});
    chk({tag, " value0"},  value0, v0);
    chk({tag, " value1"},  value1, v1);
    chk({tag, " vvalid"},  {30'd0, vv0, vv1}, {30'd0, vv, vv});
    chk({tag, " ovf"},     {30'd0, ovf0, ovf1}, {30'd0, ov, ov});
    chk({tag, " unf"},     {30'd0, unf0, unf1}, {30'd0, un, un});
  endtask

  task automatic drive(input logic pu, po, cl, cm, input logic [3:0] d);
    push = pu; pop = po; clear = cl; commit = cm; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] n;
    RESET = 1'b1; push = 0; pop = 0; clear = 0; commit = 0; din = 0;

    // 1..13: basic push/pop/edit/underflow/commit+clear
    add(1,0,0,0,4'd1, 32'h1,   32'h1,   1, 0, 0, 0,0,0);
    add(1,0,0,0,4'd2, 32'h12,  32'h12,  2, 0, 0, 0,0,0);
    add(1,0,0,0,4'd3, 32'h123, 32'h123, 3, 0, 0, 0,0,0);
    add(0,1,0,0,4'd0, 32'h12,  32'h12,  2, 0, 0, 0,0,0);
    add(1,1,0,0,4'd7, 32'h17,  32'h17,  2, 0, 0, 0,0,0);
    add(0,1,0,0,4'd0, 32'h1,   32'h1,   1, 0, 0, 0,0,0);
    add(0,1,0,0,4'd0, 32'h0,   32'h0,   0, 0, 0, 0,0,0);
    add(0,1,0,0,4'd0, 32'h0,   32'h0,   0, 0, 0, 0,0,1);
    add(1,1,0,0,4'd4, 32'h4,   32'h4,   1, 0, 0, 0,0,0);
    add(1,0,0,0,4'd5, 32'h45,  32'h45,  2, 0, 0, 0,0,0);
    add(0,0,1,1,4'd0, 32'h0,   32'h0,   0, 32'h45, 32'h45, 1,0,0);
    add(0,0,0,0,4'd0, 32'h0,   32'h0,   0, 32'h45, 32'h45, 0,0,0);
    add(0,0,0,1,4'd0, 32'h0,   32'h0,   0, 0, 0, 1,0,0);
    // fill to full, then the ninth push
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      n = (n << 4) | 32'(i);
      add(1,0,0,0,4'(i), n, n, i, 0, 0, 0,0,0);
    end
    add(1,0,0,0,4'd9, 32'h23456789, 32'h12345678, 8, 0, 0, 0,1,0);
    add(0,0,0,0,4'd0, 32'h23456789, 32'h12345678, 8, 0, 0, 0,0,0);
    add(0,0,0,1,4'd0, 32'h23456789, 32'h12345678, 8, 32'h23456789, 32'h12345678, 1,0,0);
    add(0,1,0,0,4'd0, 32'h02345678, 32'h01234567, 7, 32'h23456789, 32'h12345678, 0,0,0);
    add(1,0,1,0,4'd3, 32'h0, 32'h0, 0, 32'h23456789, 32'h12345678, 0,0,0);
    add(0,1,1,0,4'd0, 32'h0, 32'h0, 0, 32'h23456789, 32'h12345678, 0,0,0);

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].pu, tbl[k].po, tbl[k].cl, tbl[k].cm, tbl[k].d);
      chk_state($sformatf("v%0d", k), tbl[k].n0, tbl[k].n1, tbl[k].c,
                tbl[k].v0, tbl[k].v1, tbl[k].vv, tbl[k].ov, tbl[k].un);
    end

    // Reset arriving with push+commit at count=5
    for (int i = 1; i <= 5; i++) drive(1,0,0,0,4'(i));
    chk_state("pre_rst", 32'h12345, 32'h12345, 5, 32'h23456789, 32'h12345678, 0,0,0);
    RESET = 1'b1;
    drive(1,0,0,1,4'd6);
    chk_state("rst_push", 0, 0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b0;
    drive(0,0,0,0,4'd0);
    chk_state("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);

    // Non-BCD digit handling
    drive(1,0,0,0,4'd1);
    drive(1,0,0,0,4'd2);
    drive(1,0,0,0,4'hA);
`ifdef DIGIT_ENTRY_BCD_CHECK_EN
    chk_state("bcd_A", 32'h12, 32'h12, 2, 0, 0, 0, 0, 0);
    chk("bcd_A bad_digit", {30'd0, bad0, bad1}, 32'd3);
    drive(0,0,0,0,4'd0);
    chk("bcd_idle bad_digit", {30'd0, bad0, bad1}, 32'd0);
    drive(1,0,0,0,4'd9);
    chk_state("bcd_9", 32'h129, 32'h129, 3, 0, 0, 0, 0, 0);
    chk("bcd_9 bad_digit", {30'd0, bad0, bad1}, 32'd0);
`else
    chk_state("hex_A", 32'h12A, 32'h12A, 3, 0, 0, 0, 0, 0);
    drive(0,0,0,0,4'd0);
    drive(1,0,0,0,4'd9);
    chk_state("hex_9", 32'h12A9, 32'h12A9, 4, 0, 0, 0, 0, 0);
`endif
    drive(0,0,0,0,4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/digit_entry_buffer.md
Name: digit_entry_buffer

Overview:
Parametrised successor to the switch-nibble shift register feeding the seven-segment driver. Accepts debounced one-cycle strobes for push, backspace, clear and commit. Maintains a DIGITS-deep stack of DIGIT_W-bit digits with an occupancy counter and an active-low anode mask. Supports a selectable full-buffer policy and latches a committed value for downstream logic.

Parameters:
DIGIT_W, 4, width of one digit in bits
DIGITS, 8, number of digit slots
FULL_MODE, 0, push behaviour when full: 0 = drop oldest digit and shift; 1 = reject push

Ports:
clk  in  1  system clock; all logic on its rising edge
RESET  in  1  synchronous, active-high reset
push  in  1  one-cycle strobe: append din as newest digit
pop  in  1  one-cycle strobe: remove newest digit (backspace)
clear  in  1  one-cycle strobe: empty buffer
commit  in  1  one-cycle strobe: latch current number into value
din  in  DIGIT_W  digit to append
number  out  DIGIT_W*DIGITS  live buffer; newest digit in bits [DIGIT_W-1:0]
an_mask  out  DIGITS  active-low; bit i = 0 iff slot i is occupied
count  out  $clog2(DIGITS+1)  number of occupied slots, 0..DIGITS
full  out  1  count == DIGITS
empty  out  1  count == 0
value  out  DIGIT_W*DIGITS  last committed number
value_valid  out  1  one-cycle pulse, cycle after commit
overflow  out  1  one-cycle pulse: push while full
underflow  out  1  one-cycle pulse: pop while empty

Behaviour:
- Reset (RESET=1 at clk edge): number=0, value=0, count=0, an_mask=all 1s, value_valid=0, overflow=0, underflow=0. empty=1, full=0. Reset overrides all strobes.
- All outputs registered except full/empty, which are decoded combinationally from count. Strobe effects are visible the cycle after the edge that samples them (latency 1).
- Priority per cycle: RESET > clear > push/pop. commit is independent of the others.
- clear: number=0, count=0, an_mask=all 1s. Coincident push/pop ignored; no overflow/underflow pulse.
- push only, not full: number <= {number[DIGIT_W*(DIGITS-1)-1:0], din}; count+1.
- push only, full, FULL_MODE=0: shift as above (oldest digit lost); count stays DIGITS; overflow=1.
- push only, full, FULL_MODE=1: number unchanged; overflow=1.
- pop only, not empty: number <= {DIGIT_W zeros, number[DIGIT_W*DIGITS-1:DIGIT_W]}; count-1.
- pop only, empty: no change; underflow=1.
- push and pop together, not empty: edit in place; number[DIGIT_W-1:0] <= din; count unchanged; no pulses.
- push and pop together, empty: treated as push only.
- an_mask[i] = ~(i < count), updated in the same cycle as count.
- commit: value <= number as it stood before this cycle's edit/push/pop/clear, i.e. the pre-edge register contents. value_valid=1 for exactly one cycle. Commit with clear in the same cycle latches the pre-clear number.
- overflow, underflow and value_valid are 0 in every cycle not described above.
- Strobes are assumed single-cycle. A level held N cycles acts as N strobes.

Optional Feature:
Macro DIGIT_ENTRY_BCD_CHECK_EN.
- Defined: push with din > 9 is rejected. Buffer and count are unchanged, and an extra output port bad_digit (1 bit, reset 0) pulses for one cycle. Push+pop with din > 9 is also rejected. The check applies only when DIGIT_W >= 4.
- Undefined: any din value is accepted; port bad_digit does not exist.

Test Plan:
- Reset, then push din=1,2,3 on three separate cycles -> number=0x00000123, count=3, an_mask=8'b11111000, empty=0.
- Push 9 digits 1..9 with FULL_MODE=0 -> number=0x23456789, count=8, full=1, overflow pulses once on the 9th push. Repeat with FULL_MODE=1 -> number=0x12345678, overflow pulses once.
- From 0x123 (count=3): pop -> 0x12, count=2; push+pop with din=7 -> 0x17, count=2; pop, pop, then pop again -> 0x0, count=0, underflow pulses once on the third pop.
- From 0x45 (count=2): commit and clear in the same cycle -> next cycle value=0x45, value_valid=1 for one cycle, number=0, an_mask=8'hFF.
- Assert RESET during a push strobe at count=5 -> all outputs return to reset values, and no overflow or value_valid pulse occurs.
- With DIGIT_ENTRY_BCD_CHECK_EN defined, push din=4'hA at count=2 -> number and count unchanged, bad_digit pulses once; push din=9 -> accepted.
